// File: rtl/sseg_scan_display.sv
// Latches a signed magnitude and converts it to BCD with shift-add-3, one bit per clock.
// It then time-multiplexes the units, tens and sign digits onto an active-low 7-seg display.
module sseg_scan_display #(
    parameter int DATA_W      = 6,
    parameter int REFRESH_DIV = 50000,
    parameter int NUM_AN      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    input  logic              neg,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic [0:6]        sseg,
    output logic [NUM_AN-1:0] an
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_AN > 1) ? $clog2(NUM_AN) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_AN - 1);
    localparam logic [0:6]       BLANK    = 7'b1111111;
    localparam logic [0:6]       MINUS    = 7'b1111110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [7:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [3:0]        units_q, units_d;
    logic [3:0]        tens_q, tens_d;
    logic              sign_q, sign_d;
    logic [REF_W-1:0]  ref_q, ref_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_AN-1:0] an_q, an_d;
    logic [0:6]        sseg_q, sseg_d;
    logic [7:0]        bcd_adj;
    logic [7:0]        bcd_next;

    function automatic logic [0:6] seg7(input logic [3:0] d);
        logic [0:6] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    // Conversion FSM; display registers are only written on the final shift.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        units_d  = units_q;
        tens_d   = tens_q;
        sign_d   = sign_q;
        busy     = 1'b0;
        done     = 1'b0;

        bcd_adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        bcd_adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        bcd_next     = (bcd_adj << 1) | 8'(shift_q[DATA_W-1]);

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    shift_d = value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    neg_d   = neg;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                busy    = 1'b1;
                bcd_d   = bcd_next;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    units_d = bcd_next[3:0];
                    tens_d  = bcd_next[7:4];
                    sign_d  = neg_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Free-running scan, independent of the conversion FSM.
    always_comb begin
        ref_d  = (ref_q == REF_LAST) ? '0 : ref_q + REF_W'(1);
        idx_d  = idx_q;
        an_d   = '1;
        sseg_d = BLANK;
        if (ref_q == REF_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        if (idx_q == IDX_W'(0)) begin
            an_d[0] = 1'b0;
            sseg_d  = seg7(units_q);
        end else if (idx_q == IDX_W'(1)) begin
            an_d[1] = 1'b0;
            sseg_d  = (tens_q == 4'd0) ? BLANK : seg7(tens_q);
        end else if (idx_q == IDX_W'(2)) begin
            an_d[2] = 1'b0;
            sseg_d  = sign_q ? MINUS : BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            units_q <= '0;
            tens_q  <= '0;
            sign_q  <= 1'b0;
            ref_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            sseg_q  <= BLANK;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            units_q <= units_d;
            tens_q  <= tens_d;
            sign_q  <= sign_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
        end
    end

    assign an   = an_q;
    assign sseg = sseg_q;

endmodule

// File: tb/tb_sseg_scan_display.sv
// Directed bench for sseg_scan_display with a short refresh divider.
module tb_sseg_scan_display;

    logic       clk;
    logic       rst;
    logic [5:0] value;
    logic       neg;
    logic       load;
    logic       busy;
    logic       done;
    logic [0:6] sseg;
    logic [3:0] an;

    int n_cmp;
    int n_bad;

    sseg_scan_display #(
        .DATA_W      (6),
        .REFRESH_DIV (4),
        .NUM_AN      (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .neg   (neg),
        .load  (load),
        .busy  (busy),
        .done  (done),
        .sseg  (sseg),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Waits (bounded) until the given anode pattern is shown and returns its segments.
    task automatic grab(input logic [3:0] pat, output logic [0:6] seg, output bit ok);
        ok  = 1'b0;
        seg = 7'b1111111;
        for (int i = 0; i < 40; i++) begin
            if (an === pat) begin
                ok  = 1'b1;
                seg = sseg;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [5:0] v, input logic n);
        @(negedge clk);
        value = v;
        neg   = n;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; load = 1'b0; value = '0; neg = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (an !== 4'b1111) begin n_bad++; $display("FAIL rst_an: got %b expected 1111", an); end
        n_cmp++;
        if (sseg !== 7'b1111111) begin n_bad++; $display("FAIL rst_sseg: got %b expected 1111111", sseg); end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_busy_done: got %b%b expected 00", busy, done); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (an !== 4'b1110) begin n_bad++; $display("FAIL scan_an0_c%0d: got %b expected 1110", i, an); end
        end
        n_cmp++;
        if (sseg !== 7'b0000001) begin n_bad++; $display("FAIL scan_units0: got %b expected 0000001", sseg); end
        @(negedge clk);
        n_cmp++;
        if (an !== 4'b1101) begin n_bad++; $display("FAIL scan_an1: got %b expected 1101", an); end
        n_cmp++;
        if (sseg !== 7'b1111111) begin n_bad++; $display("FAIL scan_tens_blank: got %b expected 1111111", sseg); end
    endtask

    task automatic test_conv_42;
        logic [0:6] seg;
        bit         ok;
        do_load(6'd42, 1'b0);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (busy !== (i <= 6) || done !== (i == 6)) begin
                n_bad++;
                $display("FAIL t42_timing_c%0d: got busy=%b done=%b expected busy=%b done=%b",
                         i, busy, done, (i <= 6), (i == 6));
            end
            @(negedge clk);
        end
        grab(4'b1110, seg, ok); n_cmp++;
        if (!ok || seg !== 7'b0010010) begin n_bad++; $display("FAIL t42_units: got %b ok=%0d expected 0010010", seg, ok); end
        grab(4'b1101, seg, ok); n_cmp++;
        if (!ok || seg !== 7'b1001100) begin n_bad++; $display("FAIL t42_tens: got %b ok=%0d expected 1001100", seg, ok); end
        grab(4'b1011, seg, ok); n_cmp++;
        if (!ok || seg !== 7'b1111111) begin n_bad++; $display("FAIL t42_sign: got %b ok=%0d expected 1111111", seg, ok); end
    endtask

    task automatic test_conv_63_neg;
        logic [0:6] seg;
        bit         ok;
        do_load(6'd63, 1'b1);
        repeat (10) @(negedge clk);
        grab(4'b1110, seg, ok); n_cmp++;
        if (!ok || seg !== 7'b0000110) begin n_bad++; $display("FAIL t63_units: got %b ok=%0d expected 0000110", seg, ok); end
        grab(4'b1101, seg, ok); n_cmp++;
        if (!ok || seg !== 7'b0100000) begin n_bad++; $display("FAIL t63_tens: got %b ok=%0d expected 0100000", seg, ok); end
        grab(4'b1011, seg, ok); n_cmp++;
        if (!ok || seg !== 7'b1111110) begin n_bad++; $display("FAIL t63_sign: got %b ok=%0d expected 1111110", seg, ok); end
        grab(4'b1111, seg, ok); n_cmp++;
        if (!ok || seg !== 7'b1111111) begin n_bad++; $display("FAIL t63_idx3: got %b ok=%0d expected 1111111", seg, ok); end
    endtask

    task automatic test_conv_5;
        logic [0:6] seg;
        bit         ok;
        do_load(6'd5, 1'b0);
        repeat (10) @(negedge clk);
        grab(4'b1110, seg, ok); n_cmp++;
        if (!ok || seg !== 7'b0100100) begin n_bad++; $display("FAIL t5_units: got %b ok=%0d expected 0100100", seg, ok); end
        grab(4'b1101, seg, ok); n_cmp++;
        if (!ok || seg !== 7'b1111111) begin n_bad++; $display("FAIL t5_tens: got %b ok=%0d expected 1111111", seg, ok); end
        grab(4'b1011, seg, ok); n_cmp++;
        if (!ok || seg !== 7'b1111111) begin n_bad++; $display("FAIL t5_sign: got %b ok=%0d expected 1111111", seg, ok); end
    endtask

    task automatic test_load_while_busy;
        logic [0:6] seg;
        bit         ok;
        int         dn;
        dn = 0;
        @(negedge clk);
        value = 6'd17; neg = 1'b0; load = 1'b1;
        @(negedge clk);
        value = 6'd9;
        // load stays high through CONV and DONE; both must ignore it
        for (int i = 0; i < 7; i++) begin
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        n_cmp++;
        if (dn != 1) begin n_bad++; $display("FAIL busy_done_count: got %0d expected 1", dn); end
        grab(4'b1110, seg, ok); n_cmp++;
        if (!ok || seg !== 7'b0001111) begin n_bad++; $display("FAIL busy_units: got %b ok=%0d expected 0001111", seg, ok); end
        grab(4'b1101, seg, ok); n_cmp++;
        if (!ok || seg !== 7'b1001111) begin n_bad++; $display("FAIL busy_tens: got %b ok=%0d expected 1001111", seg, ok); end
    endtask

    task automatic test_reset_mid_conv;
        logic [0:6] seg;
        bit         ok;
        int         dn;
        dn = 0;
        do_load(6'd42, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b%b expected 00", busy, done); end
        n_cmp++;
        if (an !== 4'b1111) begin n_bad++; $display("FAIL mid_rst_an: got %b expected 1111", an); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        n_cmp++;
        if (dn != 0) begin n_bad++; $display("FAIL mid_rst_done: got %0d pulses expected 0", dn); end
        grab(4'b1110, seg, ok); n_cmp++;
        if (!ok || seg !== 7'b0000001) begin n_bad++; $display("FAIL mid_rst_units: got %b ok=%0d expected 0000001", seg, ok); end
        grab(4'b1101, seg, ok); n_cmp++;
        if (!ok || seg !== 7'b1111111) begin n_bad++; $display("FAIL mid_rst_tens: got %b ok=%0d expected 1111111", seg, ok); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_conv_42();
        test_conv_63_neg();
        test_conv_5();
        test_load_while_busy();
        test_reset_mid_conv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
